// File: rtl/conv_mac_sequencer.sv
// Convolution window sequencer: streams KSIZE operand pairs through a shared pipelined
// multiplier, accumulates Q1.(DWIDTH-1) product slices onto a bias, returns one saturated result.
module conv_mac_sequencer #(
    parameter int DWIDTH    = 16,
    parameter int KSIZE     = 25,
    parameter int MULT_LAT  = 1,
    parameter int ACC_WIDTH = 21
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DWIDTH-1:0]   bias,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DWIDTH-1:0]   din,
    input  logic [DWIDTH-1:0]   win,
    output logic                mult_ce,
    output logic [DWIDTH-1:0]   mult_a,
    output logic [DWIDTH-1:0]   mult_b,
    input  logic [2*DWIDTH-1:0] mult_p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DWIDTH-1:0]   dout
);
    localparam int CW = $clog2(KSIZE + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(KSIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [CW-1:0]        issue_cnt_r, retire_cnt_r;
    logic [ACC_WIDTH-1:0] acc_r, acc_next_s;
    logic [MULT_LAT-1:0]  vld_pipe_r;
    logic [DWIDTH-1:0]    slice_s, dout_r;
    logic                 busy_r, in_ready_r, mult_ce_r, out_valid_r;
    logic                 pipe_run_s, in_hs_s, retire_s, last_issue_s, last_retire_s;

    function automatic logic [DWIDTH-1:0] sat_acc(input logic [ACC_WIDTH-1:0] a);
        logic [ACC_WIDTH-DWIDTH:0] top;
        top = a[ACC_WIDTH-1:DWIDTH-1];
        if (top == {(ACC_WIDTH-DWIDTH+1){1'b0}} || top == {(ACC_WIDTH-DWIDTH+1){1'b1}})
            sat_acc = a[DWIDTH-1:0];
        else if (a[ACC_WIDTH-1])
            sat_acc = {1'b1, {(DWIDTH-1){1'b0}}};
        else
            sat_acc = {1'b0, {(DWIDTH-1){1'b1}}};
    endfunction

    assign mult_a    = din;
    assign mult_b    = win;
    assign busy      = busy_r;
    assign in_ready  = in_ready_r;
    assign mult_ce   = mult_ce_r;
    assign out_valid = out_valid_r;
    assign dout      = dout_r;

    // Low DWIDTH bits of P >>> (DWIDTH-1) are exactly P[2*DWIDTH-2 -: DWIDTH] (floor truncation)
    assign slice_s       = DWIDTH'($signed(mult_p) >>> (DWIDTH - 1));
    assign acc_next_s    = acc_r + {{(ACC_WIDTH-DWIDTH){slice_s[DWIDTH-1]}}, slice_s};
    assign pipe_run_s    = (state_r == FEED) || (state_r == DRAIN);
    assign in_hs_s       = in_valid && (state_r == FEED);
    assign retire_s      = pipe_run_s && vld_pipe_r[MULT_LAT-1];
    assign last_issue_s  = in_hs_s && (issue_cnt_r == LAST_CNT);
    assign last_retire_s = retire_s && (retire_cnt_r == LAST_CNT);

    // Next-state decode for the window sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start) state_s = FEED; else state_s = IDLE;
            FEED:    if (last_issue_s) state_s = DRAIN; else state_s = FEED;
            DRAIN:   if (last_retire_s) state_s = OUT; else state_s = DRAIN;
            OUT:     if (out_ready) state_s = IDLE; else state_s = OUT;
            default: state_s = IDLE;
        endcase
    end

    // State register and registered control outputs decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
            mult_ce_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != IDLE);
            in_ready_r <= (state_s == FEED);
            mult_ce_r  <= (state_s == FEED) || (state_s == DRAIN);
        end
    end

    // Datapath: bias load, issue/retire bookkeeping, valid pipe, accumulation and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r        <= {ACC_WIDTH{1'b0}};
            issue_cnt_r  <= {CW{1'b0}};
            retire_cnt_r <= {CW{1'b0}};
            vld_pipe_r   <= {MULT_LAT{1'b0}};
            dout_r       <= {DWIDTH{1'b0}};
            out_valid_r  <= 1'b0;
        end else begin
            if (state_r == IDLE && start) begin
                acc_r        <= {{(ACC_WIDTH-DWIDTH){bias[DWIDTH-1]}}, bias};
                issue_cnt_r  <= {CW{1'b0}};
                retire_cnt_r <= {CW{1'b0}};
                vld_pipe_r   <= {MULT_LAT{1'b0}};
            end
            if (pipe_run_s) begin
                vld_pipe_r[0] <= in_hs_s;
                for (int i = 1; i < MULT_LAT; i++)
                    vld_pipe_r[i] <= vld_pipe_r[i-1];
            end
            if (in_hs_s)
                issue_cnt_r <= issue_cnt_r + CW'(1);
            if (retire_s) begin
                acc_r        <= acc_next_s;
                retire_cnt_r <= retire_cnt_r + CW'(1);
            end
            if (last_retire_s) begin
                dout_r      <= sat_acc(acc_next_s);
                out_valid_r <= 1'b1;
            end else if (state_r == OUT && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer: two instances (multiplier latency 1 and 3) driven by directed
// windows, checked every cycle against an arithmetic window model plus literal expectations.
module tb_conv_mac_sequencer;
    localparam int KS = 25;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       start_v = 2'b00;
    logic [15:0]      bias = 16'h0000, din = 16'h0000, win = 16'h0000;
    logic             in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]       busy_v, in_ready_v, mult_ce_v, out_valid_v;
    logic [1:0][15:0] mult_a_v, mult_b_v, dout_v;
    logic [1:0][31:0] mult_p_v;
    logic signed [31:0] m0_p;
    logic signed [31:0] m1_st [3];

    int sel = 0;
    int cyc = 0;
    int n_cmp = 0, n_err = 0;
    int start_edge = 0, last_hs_edge = 0, first_valid_edge = 0, out_seq = 0;
    int m_pairs = 0;
    longint m_acc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_dout = 16'h0000, prev_dout = 16'h0000;
    logic prev_hold = 1'b0, prev_hs = 1'b0, prev_ov = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural pipelined multipliers (latency 1 and 3) with clock enable
    always @(posedge clk) if (mult_ce_v[0]) m0_p <= $signed(mult_a_v[0]) * $signed(mult_b_v[0]);
    always @(posedge clk)
        if (mult_ce_v[1]) begin
            m1_st[0] <= $signed(mult_a_v[1]) * $signed(mult_b_v[1]);
            m1_st[1] <= m1_st[0];
            m1_st[2] <= m1_st[1];
        end
    assign mult_p_v[0] = m0_p;
    assign mult_p_v[1] = m1_st[2];

    conv_mac_sequencer #(.DWIDTH(16), .KSIZE(25), .MULT_LAT(1), .ACC_WIDTH(21)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .bias(bias), .busy(busy_v[0]),
        .in_valid(in_valid), .in_ready(in_ready_v[0]), .din(din), .win(win),
        .mult_ce(mult_ce_v[0]), .mult_a(mult_a_v[0]), .mult_b(mult_b_v[0]), .mult_p(mult_p_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .dout(dout_v[0]));

    conv_mac_sequencer #(.DWIDTH(16), .KSIZE(25), .MULT_LAT(3), .ACC_WIDTH(21)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .bias(bias), .busy(busy_v[1]),
        .in_valid(in_valid), .in_ready(in_ready_v[1]), .din(din), .win(win),
        .mult_ce(mult_ce_v[1]), .mult_a(mult_a_v[1]), .mult_b(mult_b_v[1]), .mult_p(mult_p_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .dout(dout_v[1]));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint slice_of(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p >>> 15;
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        longint c;
        if (v > 32767) c = 32767;
        else if (v < -32768) c = -32768;
        else c = v;
        return c[15:0];
    endfunction

    // Window model and per-cycle comparison against the selected instance
    always @(negedge clk) begin
        logic ir, ov, by, ce;
        logic [15:0] dq;
        int lat;
        ir  = in_ready_v[sel];
        ov  = out_valid_v[sel];
        by  = busy_v[sel];
        ce  = mult_ce_v[sel];
        dq  = dout_v[sel];
        lat = (sel == 1) ? 3 : 1;
        if (rst) begin
            m_pairs = 0;
            m_acc = 0;
            exp_q.delete();
            prev_hold = 1'b0;
            prev_hs = 1'b0;
            prev_ov = 1'b0;
        end else begin
            if (prev_hs)
                check("idle_after_handshake", {62'd0, ov, by}, 64'd0);
            else if (prev_hold)
                check("out_held", {47'd0, ov, dq}, {47'd0, 1'b1, prev_dout});
            if (ov) begin
                check("out_ce_ready_low", {62'd0, ce, ir}, 64'd0);
                check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            end
            if (ir) begin
                check("no_ready_after_last", 64'(m_pairs < KS), 64'd1);
                check("mult_ab_copy", {32'd0, mult_a_v[sel], mult_b_v[sel]}, {32'd0, din, win});
            end
            if (start_v[sel] && !by) begin
                m_acc = longint'($signed(bias));
                m_pairs = 0;
            end
            if (in_valid && ir) begin
                m_acc += slice_of(din, win);
                m_pairs++;
                last_hs_edge = cyc + 1;
                if (m_pairs == KS) exp_q.push_back(sat16(m_acc));
            end
            if (ov && !prev_ov) begin
                first_valid_edge = cyc;
                check("latency", 64'(cyc), 64'(last_hs_edge + lat));
            end
            if (ov && out_ready && exp_q.size() != 0) begin
                got_dout = dq;
                out_seq++;
                check("dout", {48'd0, dq}, {48'd0, exp_q.pop_front()});
            end
            prev_hold = ov && !out_ready;
            prev_hs   = ov && out_ready;
            prev_ov   = ov;
            prev_dout = dq;
        end
    end

    // mode 1: in_valid toggles with a gap plus extra pulses after the last pair
    task automatic run_window(input logic [15:0] b, input logic [15:0] d, input logic [15:0] w,
                              input int mode, input int hold, input int abort_after);
        int sent, n, seq0;
        logic hs;
        seq0 = out_seq;
        @(posedge clk); #1;
        bias = b;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_edge = cyc;
        start_v = 2'b00;
        sent = 0;
        n = 0;
        while (sent < KS && n < 400 && !(abort_after > 0 && sent == abort_after)) begin
            in_valid = (mode == 0) || ((n % 2 == 0) && (n < 20 || n >= 25));
            din = d;
            win = w;
            @(negedge clk);
            hs = in_valid && in_ready_v[sel];
            @(posedge clk); #1;
            if (hs) sent++;
            n++;
        end
        check("feed_count", 64'(sent), 64'((abort_after > 0) ? abort_after : KS));
        if (abort_after > 0) begin
            rst = 1'b1;
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("abort_idle", {62'd0, busy_v[sel], out_valid_v[sel]}, 64'd0);
            rst = 1'b0;
        end else begin
            n = 0;
            while (!out_valid_v[sel] && n < 200) begin
                in_valid = (mode == 1) && (n % 2 == 0);
                din = 16'h7FFF;
                win = 16'h7FFF;
                @(posedge clk); #1;
                n++;
            end
            in_valid = 1'b0;
            check("out_valid_seen", {63'd0, out_valid_v[sel]}, 64'd1);
            if (hold > 0) begin
                start_v[sel] = 1'b1;
                repeat (hold) @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            start_v = 2'b00;
            check("one_result", 64'(out_seq - seq0), 64'd1);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {62'd0, busy_v}, 64'd0);
        check("rst_in_ready", {62'd0, in_ready_v}, 64'd0);
        check("rst_mult_ce", {62'd0, mult_ce_v}, 64'd0);
        check("rst_out_valid", {62'd0, out_valid_v}, 64'd0);
        check("rst_dout", {32'd0, dout_v}, 64'd0);
        rst = 1'b0;

        run_window(16'h0010, 16'h0100, 16'h0100, 0, 0, 0);
        check("case1_dout", {48'd0, got_dout}, 64'h0042);
        check("case1_latency", 64'(first_valid_edge - start_edge), 64'd26);
        run_window(16'h0000, 16'h00E1, 16'hFF7D, 0, 0, 0);
        check("case2_dout", {48'd0, got_dout}, 64'hFFE7);
        run_window(16'h0000, 16'h4000, 16'h4000, 0, 0, 0);
        check("pos_sat_dout", {48'd0, got_dout}, 64'h7FFF);
        run_window(16'h0000, 16'h8000, 16'h7FFF, 0, 0, 0);
        check("neg_sat_dout", {48'd0, got_dout}, 64'h8000);
        run_window(16'h0010, 16'h0100, 16'h0100, 1, 0, 0);
        check("bubble_dout", {48'd0, got_dout}, 64'h0042);
        run_window(16'h0010, 16'h0100, 16'h0100, 0, 10, 0);
        check("backpressure_dout", {48'd0, got_dout}, 64'h0042);

        sel = 1;
        run_window(16'h0010, 16'h0100, 16'h0100, 0, 10, 0);
        check("lat3_dout", {48'd0, got_dout}, 64'h0042);
        check("lat3_latency", 64'(first_valid_edge - start_edge), 64'd28);

        sel = 0;
        run_window(16'h0010, 16'h0100, 16'h0100, 0, 0, 10);
        run_window(16'h0000, 16'h00E1, 16'hFF7D, 0, 0, 0);
        check("after_abort_dout", {48'd0, got_dout}, 64'hFFE7);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
